// File: rtl/mixer_ctrl_pkg.sv
//==============================================================================
// Package     : mixer_ctrl_pkg
// Description : Shared definitions for the mixer control path: frame sync
//               byte, frame-status codes, parser state encoding, default mixer
//               dimensions (shared with the coefficient store and mix engine)
//               and the frame checksum helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mixer_ctrl_pkg;

  // First byte of every host frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Frame status codes reported on ack_code.
  localparam logic [1:0] ACK_OK       = 2'd0;
  localparam logic [1:0] ACK_BAD_CSUM = 2'd1;
  localparam logic [1:0] ACK_BAD_ADDR = 2'd2;
  localparam logic [1:0] ACK_TIMEOUT  = 2'd3;

  // Default mixer dimensions. Input address 0 selects the output gain, so the
  // valid input range is 0..NUM_INPUTS inclusive.
  localparam int DEFAULT_NUM_INPUTS  = 6;
  localparam int DEFAULT_NUM_OUTPUTS = 4;

  // Parser state encoding.
  typedef enum logic [2:0] {
    ST_HUNT      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_HI        = 3'd2,
    ST_LO        = 3'd3,
    ST_CSUM      = 3'd4,
    ST_WAIT_TICK = 3'd5
  } state_e;

  // Checksum covers the address byte and both coefficient bytes.
  function automatic logic [7:0] frame_csum(input logic [7:0] addr_byte,
                                            input logic [7:0] coeff_hi,
                                            input logic [7:0] coeff_lo);
    return addr_byte ^ coeff_hi ^ coeff_lo;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mixer_frame_timer.sv
//==============================================================================
// Module      : mixer_frame_timer
// Description : Inter-byte idle counter for the frame parser. Counts cycles
//               while enabled and not cleared; o_terminal is high on the cycle
//               that is the TIMEOUT_CYCLES-th consecutive idle cycle.
// Ports       : CLK        in  clock
//               RST        in  synchronous active-high reset
//               i_clear    in  restart the count (a byte was accepted)
//               i_enable   in  count only while a frame is being received
//               o_terminal out idle limit reached this cycle
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mixer_frame_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  // r_count holds the number of idle cycles already completed, so the current
  // cycle is idle cycle r_count+1; terminal fires when that equals the limit.
  logic [c_CNT_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST || i_clear || !i_enable) begin
      r_count <= '0;
    end else if (r_count != c_LAST) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

  assign o_terminal = i_enable && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/mixer_coeff_loader.sv
//==============================================================================
// Module      : mixer_coeff_loader
// Description : Host-side write controller for the mixer coefficient store.
//               Parses framed bytes A5|addr|coeff_hi|coeff_lo|csum, validates
//               each frame, reports status, and issues the store write either
//               on the next sample_tick or directly after the checksum.
// Ports       : CLK           in   clock
//               RST           in   synchronous active-high reset
//               rx_valid      in   byte available
//               rx_data[7:0]  in   byte from host
//               rx_ready      out  byte accepted when rx_valid && rx_ready
//               sample_tick   in   audio sample boundary strobe
//               latch_out     out  one-cycle store write strobe
//               coeff_out     out  coefficient to write
//               in_addr_out   out  input (column) address
//               out_addr_out  out  output (row) address
//               busy          out  frame in progress or write pending
//               ack_valid     out  one-cycle frame status strobe
//               ack_code      out  0 OK, 1 BAD_CSUM, 2 BAD_ADDR, 3 TIMEOUT
//               err_count     out  saturating count of non-OK frames
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mixer_coeff_loader
  import mixer_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS     = DEFAULT_NUM_INPUTS,
  parameter int NUM_OUTPUTS    = DEFAULT_NUM_OUTPUTS,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit SYNC_TO_TICK   = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        sample_tick,
  output logic        latch_out,
  output logic [15:0] coeff_out,
  output logic [3:0]  in_addr_out,
  output logic [3:0]  out_addr_out,
  output logic        busy,
  output logic        ack_valid,
  output logic [1:0]  ack_code,
  output logic [7:0]  err_count
);

  state_e      r_state;
  state_e      w_state_next;

  // Frame fields captured as they arrive.
  logic [7:0]  r_addr_byte;
  logic [7:0]  r_coeff_hi;
  logic [7:0]  r_coeff_lo;

  // Registered outputs.
  logic        r_latch;
  logic        r_ack_valid;
  logic [1:0]  r_ack_code;
  logic [15:0] r_coeff_out;
  logic [3:0]  r_in_addr;
  logic [3:0]  r_out_addr;
  logic [7:0]  r_err_count;

  logic        w_accept;
  logic        w_in_frame;
  logic        w_terminal;
  logic        w_timeout;
  logic        w_csum_ok;
  logic        w_addr_ok;
  logic        w_ack_valid_next;
  logic [1:0]  w_ack_code_next;
  logic        w_latch_next;
  logic        w_load;
  logic        w_err_inc;

  // Backpressure only while a validated write waits for its sample tick.
  assign rx_ready   = (r_state != ST_WAIT_TICK);
  assign busy       = (r_state != ST_HUNT);
  assign w_accept   = rx_valid && rx_ready;
  assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_HI) ||
                      (r_state == ST_LO)   || (r_state == ST_CSUM);

  mixer_frame_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timer (
    .CLK        (CLK),
    .RST        (RST),
    .i_clear    (w_accept),
    .i_enable   (w_in_frame),
    .o_terminal (w_terminal)
  );

  // A byte arriving on the terminal cycle keeps the frame alive.
  assign w_timeout = w_terminal && !w_accept;

  // Both checks are evaluated against the checksum byte currently on rx_data;
  // they only matter in ST_CSUM.
  assign w_csum_ok = (frame_csum(r_addr_byte, r_coeff_hi, r_coeff_lo) == rx_data);
  assign w_addr_ok = (int'(r_addr_byte[7:4]) <  NUM_OUTPUTS) &&
                     (int'(r_addr_byte[3:0]) <= NUM_INPUTS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_ack_valid_next = 1'b0;
    w_ack_code_next  = r_ack_code;
    w_latch_next     = 1'b0;
    w_load           = 1'b0;
    w_err_inc        = 1'b0;

    case (r_state)
      ST_HUNT: begin
        if (w_accept && (rx_data == SYNC_BYTE)) begin
          w_state_next = ST_ADDR;
        end
      end
      ST_ADDR: if (w_accept) w_state_next = ST_HI;
      ST_HI:   if (w_accept) w_state_next = ST_LO;
      ST_LO:   if (w_accept) w_state_next = ST_CSUM;
      ST_CSUM: begin
        if (w_accept) begin
          w_ack_valid_next = 1'b1;
          w_state_next     = ST_HUNT;
          if (!w_csum_ok) begin
            w_ack_code_next = ACK_BAD_CSUM;
            w_err_inc       = 1'b1;
          end else if (!w_addr_ok) begin
            w_ack_code_next = ACK_BAD_ADDR;
            w_err_inc       = 1'b1;
          end else begin
            w_ack_code_next = ACK_OK;
            w_load          = 1'b1;
            if (SYNC_TO_TICK) begin
              w_state_next = ST_WAIT_TICK;
            end else begin
              w_latch_next = 1'b1;
            end
          end
        end
      end
      ST_WAIT_TICK: begin
        // Entered the cycle after the checksum, so a tick coincident with the
        // checksum byte is never seen here.
        if (sample_tick) begin
          w_latch_next = 1'b1;
          w_state_next = ST_HUNT;
        end
      end
      default: w_state_next = ST_HUNT;
    endcase

    // Timer is only enabled in ADDR..CSUM, and never fires on a byte cycle.
    if (w_timeout) begin
      w_state_next     = ST_HUNT;
      w_ack_valid_next = 1'b1;
      w_ack_code_next  = ACK_TIMEOUT;
      w_err_inc        = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr_byte <= '0;
      r_coeff_hi  <= '0;
      r_coeff_lo  <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_ADDR: r_addr_byte <= rx_data;
        ST_HI:   r_coeff_hi  <= rx_data;
        ST_LO:   r_coeff_lo  <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_latch     <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack_code  <= ACK_OK;
      r_coeff_out <= '0;
      r_in_addr   <= '0;
      r_out_addr  <= '0;
      r_err_count <= '0;
    end else begin
      r_latch     <= w_latch_next;
      r_ack_valid <= w_ack_valid_next;
      r_ack_code  <= w_ack_code_next;
      // Store-facing outputs change only when a validated frame loads them.
      if (w_load) begin
        r_coeff_out <= {r_coeff_hi, r_coeff_lo};
        r_in_addr   <= r_addr_byte[3:0];
        r_out_addr  <= r_addr_byte[7:4];
      end
      if (w_err_inc && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign latch_out    = r_latch;
  assign ack_valid    = r_ack_valid;
  assign ack_code     = r_ack_code;
  assign coeff_out    = r_coeff_out;
  assign in_addr_out  = r_in_addr;
  assign out_addr_out = r_out_addr;
  assign err_count    = r_err_count;

endmodule

`default_nettype wire
